// File: rtl/gsu_pkg.sv
// Shared types and constants for the GSU-side memory requester.
package gsu_pkg;

  typedef enum logic [1:0] {
    KindRomByte = 2'd0,
    KindRamByte = 2'd1,
    KindRamWord = 2'd2,
    KindRomFill = 2'd3
  } req_kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StIssue,
    StGap,
    StResp
  } state_e;

  localparam logic [23:0] SAVERAM_BASE = 24'hE00000;
  localparam int unsigned FILL_LEN     = 16;

  function automatic logic kind_is_rom(req_kind_e kind);
    return (kind == KindRomByte) || (kind == KindRomFill);
  endfunction

endpackage

// File: rtl/gsu_mem_if_if.sv
// Core request/response channel and SRAM-arbiter byte port of the GSU memory requester.
// The master modport is the requester itself; slave is the core/arbiter side.
interface gsu_mem_if_if;
  import gsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  req_kind_e   req_kind;
  logic        req_we;
  logic [7:0]  req_bank;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        rsp_valid;
  logic [15:0] rsp_data;

  logic        fill_valid;
  logic [3:0]  fill_idx;
  logic [7:0]  fill_data;

  modport master (
    input  req_valid, req_kind, req_we, req_bank, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_addr, mem_we, mem_wdata, rsp_valid, rsp_data,
           fill_valid, fill_idx, fill_data
  );

  modport slave (
    output req_valid, req_kind, req_we, req_bank, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_addr, mem_we, mem_wdata, rsp_valid, rsp_data,
           fill_valid, fill_idx, fill_data
  );

endinterface

// File: rtl/gsu_addr_map.sv
// GSU bank/offset to physical SRAM byte address, same layout as the SNES-side decode.
module gsu_addr_map
  import gsu_pkg::*;
(
  input  req_kind_e   kind_i,
  input  logic [7:0]  bank_i,
  input  logic [15:0] addr_i,
  input  logic [23:0] rom_mask_i,
  input  logic [23:0] saveram_mask_i,
  output logic [23:0] phys_addr_o
);

  logic [23:0] rom_addr;
  logic [23:0] ram_off;

  always_comb begin
    // bank[6] selects the linear 64 KiB-bank view; otherwise LoROM-style 32 KiB banks
    if (bank_i[6]) begin
      rom_addr = {2'b00, bank_i[5:0], addr_i};
    end else begin
      rom_addr = {2'b00, bank_i[6:0], addr_i[14:0]};
    end
    ram_off = {7'd0, bank_i[0], addr_i} & saveram_mask_i;
    if (kind_is_rom(kind_i)) begin
      phys_addr_o = rom_addr & rom_mask_i;
    end else begin
      phys_addr_o = SAVERAM_BASE + ram_off;
    end
  end

endmodule

// File: rtl/gsu_mem_if.sv
// GSU memory requester: core accesses to byte transactions on the shared SRAM port.
// Define GSU_MEM_FILL_EN to make kind 3 a 16-byte cache-line fill (else a single ROM byte).
module gsu_mem_if
  import gsu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [23:0]  rom_mask_i,
  input  logic [23:0]  saveram_mask_i,
  input  logic         ron_i,
  input  logic         ran_i,
  gsu_mem_if_if.master bus
);

`ifdef GSU_MEM_FILL_EN
  localparam int unsigned CntW = 4;
`else
  localparam int unsigned CntW = 1;
`endif

  state_e          state_q, state_d;
  req_kind_e       kind_q;
  logic            we_q;
  logic [7:0]      bank_q;
  logic [15:0]     addr_q;
  logic [15:0]     wdata_q;
  logic [15:0]     rdata_q;
  logic [CntW-1:0] cnt_q;

  logic        accept, byte_done, last_byte, bus_ok, new_bus_ok;
  logic [16:0] ram_seq;
  logic [7:0]  map_bank;
  logic [15:0] map_addr;
  logic [23:0] phys_addr;

  assign accept     = (state_q == StIdle) && bus.req_valid;
  assign byte_done  = (state_q == StIssue) && bus.mem_ack;
  assign bus_ok     = kind_is_rom(kind_q) ? ron_i : ran_i;
  assign new_bus_ok = kind_is_rom(bus.req_kind) ? ron_i : ran_i;

`ifdef GSU_MEM_FILL_EN
  assign last_byte = (kind_q == KindRomFill) ? (cnt_q == 4'(FILL_LEN - 1)) :
                     (kind_q == KindRamWord) ? cnt_q[0] : 1'b1;
`else
  assign last_byte = (kind_q == KindRamWord) ? cnt_q[0] : 1'b1;
`endif

  // Per-byte GSU address: RAM words step with a 17-bit wrap, fills walk the 16-byte line
  always_comb begin
    ram_seq  = {bank_q[0], addr_q} + 17'(cnt_q);
    map_bank = bank_q;
    map_addr = addr_q;
    if (!kind_is_rom(kind_q)) begin
      map_bank = {bank_q[7:1], ram_seq[16]};
      map_addr = ram_seq[15:0];
    end
`ifdef GSU_MEM_FILL_EN
    if (kind_q == KindRomFill) begin
      map_addr = {addr_q[15:4], cnt_q};
    end
`endif
  end

  gsu_addr_map u_addr_map (
    .kind_i         (kind_q),
    .bank_i         (map_bank),
    .addr_i         (map_addr),
    .rom_mask_i     (rom_mask_i),
    .saveram_mask_i (saveram_mask_i),
    .phys_addr_o    (phys_addr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = new_bus_ok ? StIssue : StHold;
      StHold:  if (bus_ok) state_d = StIssue;
      StIssue: if (bus.mem_ack) state_d = StGap;
      StGap: begin
        if (last_byte) begin
          state_d = StResp;
        end else begin
          state_d = bus_ok ? StIssue : StHold;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      kind_q  <= KindRomByte;
      we_q    <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        kind_q  <= bus.req_kind;
        we_q    <= bus.req_we && !kind_is_rom(bus.req_kind);
        bank_q  <= bus.req_bank;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        cnt_q   <= '0;
      end
      if (byte_done && !we_q) begin
        if (cnt_q == '0) begin
          rdata_q[7:0] <= bus.mem_rdata;
        end else if (cnt_q == CntW'(1)) begin
          rdata_q[15:8] <= bus.mem_rdata;
        end
      end
      if ((state_q == StGap) && !last_byte) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

`ifdef GSU_MEM_FILL_EN
  logic       fill_valid_q;
  logic [3:0] fill_idx_q;
  logic [7:0] fill_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_data_q  <= '0;
    end else begin
      fill_valid_q <= byte_done && (kind_q == KindRomFill);
      if (byte_done && (kind_q == KindRomFill)) begin
        fill_idx_q  <= cnt_q;
        fill_data_q <= bus.mem_rdata;
      end
    end
  end
`endif

  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.mem_req   = (state_q == StIssue);
    bus.mem_addr  = (state_q == StIssue) ? phys_addr : '0;
    bus.mem_we    = (state_q == StIssue) && we_q;
    bus.mem_wdata = '0;
    if ((state_q == StIssue) && we_q) begin
      bus.mem_wdata = cnt_q[0] ? wdata_q[15:8] : wdata_q[7:0];
    end
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_data  = ((state_q == StResp) && !we_q) ? rdata_q : '0;
`ifdef GSU_MEM_FILL_EN
    bus.fill_valid = fill_valid_q;
    bus.fill_idx   = fill_idx_q;
    bus.fill_data  = fill_data_q;
`else
    bus.fill_valid = 1'b0;
    bus.fill_idx   = '0;
    bus.fill_data  = '0;
`endif
  end

endmodule
